// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared state encoding and default width for the carry-save sequential multiplier
package csa_pkg;

    localparam int CSA_WIDTH_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } csa_state_e;

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - N-bit combinational 3:2 compressor, carry vector pre-shifted left with the top carry dropped
module csa_row #(
    parameter int N = 48
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] z_i,
    output logic [N-1:0] sum_o,
    output logic [N-1:0] carry_o
);

    // The majority of the top bit would land at weight 2^N; the product never needs it.
    logic [N-2:0] maj;

    assign maj     = (x_i[N-2:0] & y_i[N-2:0])
                   | (x_i[N-2:0] & z_i[N-2:0])
                   | (y_i[N-2:0] & z_i[N-2:0]);
    assign sum_o   = x_i ^ y_i ^ z_i;
    assign carry_o = {maj, 1'b0};

endmodule

// File: rtl/csa_seq_mult.sv
// rtl/csa_seq_mult.sv - sequential unsigned multiplier, one carry-save row per cycle; CSA_SEQ_MULT_EARLY_EN enables early exit
module csa_seq_mult
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;

    csa_state_e      state_q;
    logic [PW-1:0]   a_sh_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]   sum_q;
    logic [PW-1:0]   carry_q;
    logic [PW-1:0]   out_p_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum_d;
    logic [PW-1:0]   carry_d;
    logic            last_row;

    // a_sh_q already sits at the weight of the multiplier bit in b_q[0].
    assign pp = b_q[0] ? a_sh_q : '0;

    csa_row #(.N(PW)) u_row (
        .x_i     (sum_q),
        .y_i     (carry_q),
        .z_i     (pp),
        .sum_o   (sum_d),
        .carry_o (carry_d)
    );

`ifdef CSA_SEQ_MULT_EARLY_EN
    // Remaining multiplier bits all zero: further rows would only add zero.
    assign last_row = (b_q[WIDTH-1:1] == '0);
`else
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt_q;

    assign last_row = (cnt_q == CW'(WIDTH - 1));

    // Row counter: index of the multiplier bit being compressed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCUM) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`endif

    // Control FSM with registered handshake outputs, plus operand and accumulator updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            out_p_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q     <= PW'(in_a);
                        b_q        <= in_b;
                        sum_q      <= '0;
                        carry_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    a_sh_q  <= a_sh_q << 1;
                    b_q     <= b_q >> 1;
                    if (last_row) begin
                        state_q <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    out_p_q     <= sum_q + carry_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_p     = out_p_q;

endmodule

// File: tb/tb_csa_seq_mult.sv
// tb/tb_csa_seq_mult.sv - self-checking bench for csa_seq_mult (WIDTH=24), behavioural cycle-count model plus directed literals
module tb_csa_seq_mult;

    localparam int W = 24;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_p;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    csa_seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Edges from acceptance to out_valid, derived from the multiplier value.
    function automatic int exp_lat(input logic [W-1:0] b);
        int hi;
        hi = 0;
        for (int i = 0; i < W; i++) if (b[i]) hi = i;
`ifdef CSA_SEQ_MULT_EARLY_EN
        return hi + 2;
`else
        return W + 1;
`endif
    endfunction

    // Behavioural model: 0 idle, 1 computing (countdown), 2 product presented.
    int             m_st = 0;
    int             m_cnt = 0;
    logic [2*W-1:0] m_pend = '0;
    logic [2*W-1:0] m_p = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st  = 0;
            m_cnt = 0;
            m_p   = '0;
        end else begin
            if (m_st == 0) begin
                if (in_valid) begin
                    m_pend = (2*W)'(in_a) * (2*W)'(in_b);
                    m_cnt  = exp_lat(in_b);
                    m_st   = 1;
                end
            end else if (m_st == 1) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_p  = m_pend;
                    m_st = 2;
                end
            end else begin
                if (out_ready) m_st = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out_valid", 64'(out_valid), 64'(m_st == 2));
            chk("cyc_busy",      64'(busy),      64'(m_st != 0));
            chk("cyc_in_ready",  64'(in_ready),  64'(m_st == 0));
            chk("cyc_out_p",     64'(out_p),     64'(m_p));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                          output int lat, output logic [2*W-1:0] p);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 200) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!out_valid) begin
            chk("op_timeout", 64'(0), 64'(1));
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        p         = out_p;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int             lat;
        logic [2*W-1:0] p;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_out_p",     64'(out_p),     64'(0));
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run_op(24'hFFFFFF, 24'hFFFFFF, 0, lat, p);
        chk("ffxff_p",   64'(p),   64'h0000_FFFF_FE00_0001);
        chk("ffxff_lat", 64'(lat), 64'(25));

        run_op(24'h800000, 24'h800000, 0, lat, p);
        chk("8x8_p",   64'(p),   64'h0000_4000_0000_0000);
        chk("8x8_lat", 64'(lat), 64'(25));
        #1 chk("b2b_in_ready", 64'(in_ready), 64'(1));

        run_op(24'd5, 24'd3, 0, lat, p);
        chk("5x3_p", 64'(p), 64'd15);
`ifdef CSA_SEQ_MULT_EARLY_EN
        chk("5x3_lat", 64'(lat), 64'(3));
`else
        chk("5x3_lat", 64'(lat), 64'(25));
`endif

        run_op(24'h123456, 24'h000010, 10, lat, p);
        chk("stall_p", 64'(p), 64'h0000_0000_0123_4560);

        @(negedge clk);
        in_valid = 1'b1; in_a = 24'h00ABCD; in_b = 24'h000100;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!out_valid) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'(i & 1);
        end
        chk("hold_out_valid", 64'(out_valid), 64'(1));
        chk("hold_in_ready",  64'(in_ready),  64'(0));
        chk("hold_out_p",     64'(out_p),     64'h0000_0000_00AB_CD00);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("hold_p_after", 64'(out_p), 64'h0000_0000_00AB_CD00);

        run_op(24'h7FFFFF, 24'd0, 0, lat, p);
        chk("bzero_p", 64'(p), 64'd0);
`ifdef CSA_SEQ_MULT_EARLY_EN
        chk("bzero_lat", 64'(lat), 64'(2));
`else
        chk("bzero_lat", 64'(lat), 64'(25));
`endif
        run_op(24'd0, 24'hFFFFFF, 0, lat, p);
        chk("azero_p",   64'(p),   64'd0);
        chk("azero_lat", 64'(lat), 64'(25));

        run_op(24'd7, 24'd9, 0, lat, p);
        @(negedge clk);
        in_valid = 1'b1; in_a = 24'h000123; in_b = 24'hFFFABC;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_busy",      64'(busy),      64'(0));
        chk("mid_rst_out_p",     64'(out_p),     64'(0));
        chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run_op(24'd7, 24'd9, 1, lat, p);
        chk("post_rst_p", 64'(p), 64'd63);

        for (int k = 0; k < 1500; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (k % 10 == 1) rb = W'(rb >> $urandom_range(0, W - 1));
            run_op(ra, rb, int'($urandom_range(0, 2)), lat, p);
            chk("rand_p",   64'(p),   64'(ra) * 64'(rb));
            chk("rand_lat", 64'(lat), 64'(exp_lat(rb)));
        end

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
